spi_xfer_seq: RTL

Hardware transfer sequencer that drives the spi_core register port directly, with no software in the loop. It accepts one SPI transfer request at a time over a valid/ready interface. For each request it programs the divider, slave-select, TX data and control registers, polls for completion, reads the RX data and deselects the slave. It then returns the received word on a response valid/ready interface. It sits beside spi_core inside the SPI subsystem and is used for boot-time flash fetch and other autonomous accesses.

---
 rtl/spi_xfer_seq_if.sv | 39 +++
 rtl/spi_xfer_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_seq_if.sv
// Bundle of the request, response and spi_core register-port signals used by spi_xfer_seq.
// The master modport is the sequencer's view; slave is the requester/spi_core side.
interface spi_xfer_seq_if #(
  parameter int unsigned SS_NB = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_data;
  logic [4:0]       req_len;
  logic [SS_NB-1:0] req_ss;
  logic [15:0]      req_div;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic             rsp_err;

  logic             reg_we;
  logic             reg_re;
  logic [7:0]       reg_addr;
  logic [31:0]      reg_wdata;
  logic [3:0]       reg_be;
  logic [31:0]      reg_rdata;
  logic             reg_error;

  logic             busy;

  modport master (
    input  req_valid, req_data, req_len, req_ss, req_div, rsp_ready, reg_rdata, reg_error,
    output req_ready, rsp_valid, rsp_data, rsp_err, reg_we, reg_re, reg_addr, reg_wdata,
           reg_be, busy
  );

  modport slave (
    output req_valid, req_data, req_len, req_ss, req_div, rsp_ready, reg_rdata, reg_error,
    input  req_ready, rsp_valid, rsp_data, rsp_err, reg_we, reg_re, reg_addr, reg_wdata,
           reg_be, busy
  );
endinterface

// File: rtl/spi_xfer_seq.sv
// Autonomous SPI transfer sequencer: programs spi_core registers for one request, polls
// GO_BSY, reads RX, deselects the slave and returns the received word.
module spi_xfer_seq #(
  parameter int unsigned SS_NB       = 8,
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter int unsigned CNT_W       = 16
) (
  input logic            clk_i,
  input logic            rst_ni,
  spi_xfer_seq_if.master bus
);

  localparam logic [7:0] AddrData = 8'h00;
  localparam logic [7:0] AddrCtrl = 8'h10;
  localparam logic [7:0] AddrDiv  = 8'h14;
  localparam logic [7:0] AddrSs   = 8'h18;

  typedef enum logic [3:0] {
    StIdle,
    StWrDiv,
    StWrSs,
    StWrTx,
    StWrCtrl,
    StPoll,
    StRdRx,
    StAbort,
    StWrSsClr,
    StResp
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             err_q, err_d;
  logic [31:0]      data_q, data_d;
  logic [4:0]       len_q, len_d;
  logic [SS_NB-1:0] ss_q, ss_d;
  logic [15:0]      div_q, div_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;
  logic             we_q, we_d;
  logic             re_q, re_d;
  logic [7:0]       addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [6:0]       char_len;
  logic             accept;

  assign accept   = req_ready_q & bus.req_valid;
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign char_len = (len_d == 5'd0) ? 7'd32 : {2'b00, len_d};

  // Next state, request latches, poll counter, sticky error and response data.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    data_d     = data_q;
    len_d      = len_q;
    ss_d       = ss_q;
    div_d      = div_q;
    rsp_data_d = rsp_data_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d    = StWrDiv;
          data_d     = bus.req_data;
          len_d      = bus.req_len;
          ss_d       = bus.req_ss;
          div_d      = bus.req_div;
          cnt_d      = '0;
          err_d      = 1'b0;
          rsp_data_d = '0;
        end
      end
      StWrDiv:  state_d = StWrSs;
      StWrSs:   state_d = StWrTx;
      StWrTx:   state_d = StWrCtrl;
      StWrCtrl: state_d = StPoll;
      StPoll: begin
        cnt_d = cnt_inc;
        if (!bus.reg_rdata[8]) begin
          state_d = StRdRx;
        end else if (cnt_inc == CNT_W'(TIMEOUT_CYC)) begin
          state_d = StAbort;
        end
      end
      StRdRx: begin
        rsp_data_d = bus.reg_rdata;
        state_d    = StWrSsClr;
      end
      StAbort: begin
        err_d   = 1'b1;
        state_d = StWrSsClr;
      end
      StWrSsClr: state_d = StResp;
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // An access error on any strobe skips straight to deselect; a failed deselect is final.
    if ((we_q || re_q) && bus.reg_error) begin
      err_d = 1'b1;
      if (state_q == StRdRx) rsp_data_d = '0;
      state_d = (state_q == StWrSsClr) ? StResp : StWrSsClr;
    end
  end

  // Outputs are decoded from the next state so each strobe is registered with its state.
  always_comb begin
    we_d        = 1'b0;
    re_d        = 1'b0;
    addr_d      = 8'h00;
    wdata_d     = 32'h0;
    req_ready_d = (state_d == StIdle);
    busy_d      = (state_d != StIdle);
    rsp_valid_d = (state_d == StResp);

    unique case (state_d)
      StWrDiv: begin
        we_d    = 1'b1;
        addr_d  = AddrDiv;
        wdata_d = {16'h0, div_d};
      end
      StWrSs: begin
        we_d    = 1'b1;
        addr_d  = AddrSs;
        wdata_d = 32'(ss_d);
      end
      StWrTx: begin
        we_d    = 1'b1;
        addr_d  = AddrData;
        wdata_d = data_d;
      end
      StWrCtrl: begin
        we_d    = 1'b1;
        addr_d  = AddrCtrl;
        // TX_NEG | GO_BSY | CHAR_LEN
        wdata_d = 32'h0000_0500 | {25'h0, char_len};
      end
      StPoll: begin
        re_d   = 1'b1;
        addr_d = AddrCtrl;
      end
      StRdRx: begin
        re_d   = 1'b1;
        addr_d = AddrData;
      end
      StAbort: begin
        we_d   = 1'b1;
        addr_d = AddrCtrl;
      end
      StWrSsClr: begin
        we_d   = 1'b1;
        addr_d = AddrSs;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      data_q      <= '0;
      len_q       <= '0;
      ss_q        <= '0;
      div_q       <= '0;
      rsp_data_q  <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      data_q      <= data_d;
      len_q       <= len_d;
      ss_q        <= ss_d;
      div_q       <= div_d;
      rsp_data_q  <= rsp_data_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      we_q        <= we_d;
      re_q        <= re_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = err_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_re    = re_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_be    = 4'hF;
  assign bus.busy      = busy_q;

endmodule
